// File: rtl/mac_cluster_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : mac_cluster_pipe_if
// Brief    : Operand/config/result bundle for mac_cluster_pipe.
// Revision : 1.0
// ============================================================================
interface mac_cluster_pipe_if #(
    parameter int NUM_LANES  = 4,
    parameter int MIN_WIDTH  = 8,
    parameter int ACC_WIDTH  = 4*MIN_WIDTH,
    parameter int CONF_WIDTH = 5
);
    logic                                     cset;
    logic                                     en;
    logic                                     in_valid;
    logic [NUM_LANES*MIN_WIDTH-1:0]           a;
    logic [NUM_LANES*MIN_WIDTH-1:0]           b;
    logic [NUM_LANES*ACC_WIDTH+CONF_WIDTH-1:0] cfg;
    logic [NUM_LANES*ACC_WIDTH-1:0]           out;
    logic                                     out_valid;
    logic [NUM_LANES-1:0]                     ovf;

    modport master (
        output cset, en, in_valid, a, b, cfg,
        input  out, out_valid, ovf
    );

    modport slave (
        input  cset, en, in_valid, a, b, cfg,
        output out, out_valid, ovf
    );
endinterface
`default_nettype wire

// File: rtl/mac_cluster_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mac_cluster_pipe
// Brief    : NUM_LANES-lane MAC, lanes grouped 1/2/4 per quad, 2-stage pipe,
//            global stall, cset preload, optional saturation, sticky overflow.
// Revision : 1.0
// ============================================================================
module mac_cluster_pipe #(
    parameter int NUM_LANES  = 4,
    parameter int MIN_WIDTH  = 8,
    parameter int ACC_WIDTH  = 4*MIN_WIDTH,
    parameter int CONF_WIDTH = 5
) (
    input  wire logic          clk,
    input  wire logic          rst,
    mac_cluster_pipe_if.slave  bus
);
    localparam int c_PW = 2*NUM_LANES*MIN_WIDTH;
    localparam int c_AW = NUM_LANES*ACC_WIDTH;

    logic [CONF_WIDTH-1:0] r_mode;
    logic [c_PW-1:0]       r_p;
    logic                  r_v1;
    logic [c_AW-1:0]       r_acc;
    logic                  r_out_valid;
    logic [NUM_LANES-1:0]  r_ovf;

    logic w_accum;
    logic w_signed;
    logic w_sat;

    assign w_accum  = r_mode[2];
    assign w_signed = r_mode[3];
    assign w_sat    = r_mode[4];

    // Index 0/1/2 = group of 1/2/4 lanes; every size is evaluated, mode selects.
    logic [2:0][c_PW-1:0]      w_prod_all;
    logic [2:0][c_AW-1:0]      w_acc_all;
    logic [2:0][NUM_LANES-1:0] w_ovf_all;

    for (genvar gs = 0; gs < 3; gs++) begin : g_size
        localparam int c_GRP = 1 << gs;
        localparam int c_OPW = c_GRP*MIN_WIDTH;
        localparam int c_PRW = 2*c_OPW;
        localparam int c_GAW = c_GRP*ACC_WIDTH;

        for (genvar k = 0; k < NUM_LANES/c_GRP; k++) begin : g_grp
            logic [c_PRW-1:0] w_ax;
            logic [c_PRW-1:0] w_bx;
            logic [c_PRW-1:0] w_p;
            logic [c_GAW-1:0] w_ext;
            logic [c_GAW-1:0] w_acc;
            logic [c_GAW-1:0] w_res;
            logic [c_GAW:0]   w_sum;
            logic             w_ovf;

            // Operands widened to product width so one multiplier serves both signednesses.
            assign w_ax = {{c_OPW{w_signed & bus.a[k*c_OPW + c_OPW - 1]}}, bus.a[k*c_OPW +: c_OPW]};
            assign w_bx = {{c_OPW{w_signed & bus.b[k*c_OPW + c_OPW - 1]}}, bus.b[k*c_OPW +: c_OPW]};
            assign w_prod_all[gs][k*c_PRW +: c_PRW] = w_ax * w_bx;

            assign w_p   = r_p[k*c_PRW +: c_PRW];
            assign w_ext = {{(c_GAW-c_PRW){w_signed & w_p[c_PRW-1]}}, w_p};
            assign w_acc = r_acc[k*c_GAW +: c_GAW];
            assign w_sum = {1'b0, w_acc} + {1'b0, w_ext};

            assign w_ovf = w_accum & (w_signed
                         ? ((w_acc[c_GAW-1] == w_ext[c_GAW-1]) && (w_sum[c_GAW-1] != w_acc[c_GAW-1]))
                         : w_sum[c_GAW]);

            always_comb begin
                if (!w_accum) begin
                    w_res = w_ext;
                end else if (w_ovf && w_sat) begin
                    if (!w_signed)
                        w_res = '1;
                    else if (w_acc[c_GAW-1])
                        w_res = {1'b1, {(c_GAW-1){1'b0}}};
                    else
                        w_res = {1'b0, {(c_GAW-1){1'b1}}};
                end else begin
                    w_res = w_sum[c_GAW-1:0];
                end
            end

            assign w_acc_all[gs][k*c_GAW +: c_GAW] = w_res;
            assign w_ovf_all[gs][k*c_GRP +: c_GRP] = {c_GRP{w_ovf}};
        end
    end

    logic [c_PW-1:0]      w_p_next;
    logic [c_AW-1:0]      w_acc_next;
    logic [NUM_LANES-1:0] w_ovf_next;

    always_comb begin
        w_p_next   = w_prod_all[0];
        w_acc_next = w_acc_all[0];
        w_ovf_next = w_ovf_all[0];
        case (r_mode[1:0])
            2'd1: begin
                w_p_next   = w_prod_all[1];
                w_acc_next = w_acc_all[1];
                w_ovf_next = w_ovf_all[1];
            end
            2'd2: begin
                w_p_next   = w_prod_all[2];
                w_acc_next = w_acc_all[2];
                w_ovf_next = w_ovf_all[2];
            end
            default: ;
        endcase
    end

    // Mode only changes on cset, which also kills v1, so p and mode never disagree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode      <= '0;
            r_p         <= '0;
            r_v1        <= 1'b0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_ovf       <= '0;
        end else if (bus.cset) begin
            r_mode      <= bus.cfg[CONF_WIDTH-1:0];
            r_acc       <= bus.cfg[CONF_WIDTH +: c_AW];
            r_v1        <= 1'b0;
            r_out_valid <= 1'b0;
            r_ovf       <= '0;
        end else if (bus.en) begin
            r_p         <= w_p_next;
            r_v1        <= bus.in_valid;
            r_out_valid <= r_v1;
            if (r_v1) begin
                r_acc <= w_acc_next;
                r_ovf <= r_ovf | w_ovf_next;
            end
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.out       = r_acc;
    assign bus.out_valid = r_out_valid;
    assign bus.ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_mac_cluster_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_cluster_pipe
// Brief    : Directed and random checks of mac_cluster_pipe against an
//            arithmetic reference model.
// Revision : 1.0
// ============================================================================
module tb_mac_cluster_pipe;
    localparam int NUM_LANES  = 4;
    localparam int MIN_WIDTH  = 8;
    localparam int ACC_WIDTH  = 32;
    localparam int CONF_WIDTH = 5;
    localparam int c_CFGW     = NUM_LANES*ACC_WIDTH + CONF_WIDTH;

    typedef logic signed [271:0] big_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mac_cluster_pipe_if #(
        .NUM_LANES(NUM_LANES), .MIN_WIDTH(MIN_WIDTH),
        .ACC_WIDTH(ACC_WIDTH), .CONF_WIDTH(CONF_WIDTH)
    ) bus ();

    mac_cluster_pipe #(
        .NUM_LANES(NUM_LANES), .MIN_WIDTH(MIN_WIDTH),
        .ACC_WIDTH(ACC_WIDTH), .CONF_WIDTH(CONF_WIDTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int    tests = 0;
    int    fails = 0;
    string step  = "init";

    logic [31:0] m_acc [4];
    logic [3:0]  m_ovf;
    logic [4:0]  m_mode;
    logic        m_v1;
    logic        m_ov;
    logic [31:0] m_pa;
    logic [31:0] m_pb;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s/%s observed=%0h expected=%0h", step, tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] model_out();
        return {m_acc[3], m_acc[2], m_acc[1], m_acc[0]};
    endfunction

    function automatic logic [c_CFGW-1:0] cfg_of(input logic [4:0] mode, input logic [31:0] i0,
                                                 input logic [31:0] i1, input logic [31:0] i2,
                                                 input logic [31:0] i3);
        return {i3, i2, i1, i0, mode};
    endfunction

    function automatic big_t field(input logic [31:0] v, input int lsb, input int w, input bit sgn);
        big_t r;
        r = 0;
        for (int i = 0; i < w; i++) r[i] = v[lsb+i];
        if (sgn && r[w-1]) r = r - (big_t'(1) <<< w);
        return r;
    endfunction

    task automatic model_reset();
        for (int l = 0; l < 4; l++) m_acc[l] = '0;
        m_ovf = '0; m_mode = '0; m_v1 = 1'b0; m_ov = 1'b0; m_pa = '0; m_pb = '0;
    endtask

    // Group results as true integers, then range-checked, clamped or wrapped.
    task automatic apply_beat(input logic [31:0] aa, input logic [31:0] bb);
        int g;
        int ow;
        int aw;
        bit sgn;
        bit accm;
        bit sat;
        big_t opa, opb, accv, sum, lo, hi, res;
        g    = (m_mode[1:0] == 2'd1) ? 2 : (m_mode[1:0] == 2'd2) ? 4 : 1;
        sgn  = m_mode[3];
        accm = m_mode[2];
        sat  = m_mode[4];
        ow   = 8*g;
        aw   = 32*g;
        for (int k = 0; k < 4/g; k++) begin
            opa  = field(aa, k*ow, ow, sgn);
            opb  = field(bb, k*ow, ow, sgn);
            accv = 0;
            for (int l = 0; l < g; l++) accv[l*32 +: 32] = m_acc[k*g+l];
            if (sgn && accv[aw-1]) accv = accv - (big_t'(1) <<< aw);
            sum = accm ? accv + opa*opb : opa*opb;
            lo  = sgn ? -(big_t'(1) <<< (aw-1)) : big_t'(0);
            hi  = sgn ? (big_t'(1) <<< (aw-1)) - 1 : (big_t'(1) <<< aw) - 1;
            res = sum;
            if (accm && (sum < lo || sum > hi)) begin
                for (int l = 0; l < g; l++) m_ovf[k*g+l] = 1'b1;
                if (sat) res = (sum > hi) ? hi : lo;
            end
            for (int l = 0; l < g; l++) m_acc[k*g+l] = res[l*32 +: 32];
        end
    endtask

    task automatic cycle(input bit c, input bit e, input bit v, input logic [31:0] aa,
                         input logic [31:0] bb, input logic [c_CFGW-1:0] cf);
        @(negedge clk);
        bus.cset = c; bus.en = e; bus.in_valid = v; bus.a = aa; bus.b = bb; bus.cfg = cf;
        @(posedge clk);
        if (c) begin
            m_mode = cf[4:0];
            for (int l = 0; l < 4; l++) m_acc[l] = cf[5+32*l +: 32];
            m_v1 = 1'b0; m_ov = 1'b0; m_ovf = '0;
        end else if (e) begin
            if (m_v1) apply_beat(m_pa, m_pb);
            m_ov = m_v1;
            m_pa = aa; m_pb = bb; m_v1 = v;
        end else begin
            m_ov = 1'b0;
        end
        #1;
        chk("out", bus.out, model_out());
        chk("out_valid", 128'(bus.out_valid), 128'(m_ov));
        chk("ovf", 128'(bus.ovf), 128'(m_ovf));
    endtask

    task automatic beat(input logic [31:0] aa, input logic [31:0] bb);
        cycle(1'b0, 1'b1, 1'b1, aa, bb, '0);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b1, 1'b0, '0, '0, '0);
    endtask

    task automatic setcfg(input logic [c_CFGW-1:0] cf);
        cycle(1'b1, 1'b1, 1'b0, '0, '0, cf);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.cset = 1'b0; bus.en = 1'b0; bus.in_valid = 1'b0;
        bus.a = '0; bus.b = '0; bus.cfg = '0;
        model_reset();
        #1;
        step = "reset";
        chk("out", bus.out, 128'd0);
        chk("out_valid", 128'(bus.out_valid), 128'd0);
        chk("ovf", 128'(bus.ovf), 128'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        step = "single_u_acc";
        setcfg(cfg_of(5'h04, 0, 0, 0, 0));
        beat(32'hFF, 32'hFF);
        beat(32'hFF, 32'hFF);
        chk("first", 128'(bus.out[31:0]), 128'd65025);
        chk("first_valid", 128'(bus.out_valid), 128'd1);
        beat(32'hFF, 32'hFF);
        chk("second", 128'(bus.out[31:0]), 128'd130050);
        idle();
        chk("third", 128'(bus.out[31:0]), 128'd195075);
        idle();

        step = "single_s";
        setcfg(cfg_of(5'h08, 0, 0, 0, 0));
        beat(32'h7F8003FF, 32'h81800402);
        idle();
        chk("lane0", 128'(bus.out[31:0]), 128'hFFFFFFFE);
        chk("lane1", 128'(bus.out[63:32]), 128'd12);
        chk("lane2", 128'(bus.out[95:64]), 128'd16384);
        chk("lane3", 128'(bus.out[127:96]), 128'hFFFFC0FF);

        step = "dual_u";
        setcfg(cfg_of(5'h01, 0, 0, 0, 0));
        beat(32'h00000100, 32'h00000100);
        idle();
        chk("lane0", 128'(bus.out[31:0]), 128'h00010000);
        chk("lane1", 128'(bus.out[63:32]), 128'd0);

        step = "sat_ovf";
        setcfg(cfg_of(5'h1C, 32'h7FFFFFF0, 0, 0, 0));
        beat(32'h7F, 32'h7F);
        idle();
        chk("lane0", 128'(bus.out[31:0]), 128'h7FFFFFFF);
        chk("ovf0", 128'(bus.ovf[0]), 128'd1);

        step = "wrap_ovf";
        setcfg(cfg_of(5'h0C, 32'h7FFFFFF0, 0, 0, 0));
        chk("ovf_clear", 128'(bus.ovf), 128'd0);
        beat(32'h7F, 32'h7F);
        idle();
        chk("lane0", 128'(bus.out[31:0]), 128'h80003EF1);
        chk("ovf0", 128'(bus.ovf[0]), 128'd1);
        setcfg(cfg_of(5'h00, 0, 0, 0, 0));
        chk("ovf_clear", 128'(bus.ovf), 128'd0);

        step = "stall";
        setcfg(cfg_of(5'h04, 0, 0, 0, 0));
        beat(32'd2, 32'd3);
        repeat (3) begin
            cycle(1'b0, 1'b0, 1'b1, 32'd7, 32'd7, '0);
            chk("frozen", 128'(bus.out[31:0]), 128'd0);
            chk("frozen_valid", 128'(bus.out_valid), 128'd0);
        end
        idle();
        chk("resume", 128'(bus.out[31:0]), 128'd6);
        chk("resume_valid", 128'(bus.out_valid), 128'd1);

        step = "flush";
        setcfg(cfg_of(5'h04, 32'd5, 0, 0, 0));
        beat(32'd2, 32'd3);
        setcfg(cfg_of(5'h04, 32'd9, 0, 0, 0));
        idle();
        idle();
        chk("lane0", 128'(bus.out[31:0]), 128'd9);
        chk("valid", 128'(bus.out_valid), 128'd0);

        step = "async_reset";
        setcfg(cfg_of(5'h1C, 32'd1, 32'd2, 32'd3, 32'd4));
        beat(32'h05060708, 32'h01020304);
        beat(32'h05060708, 32'h01020304);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("out", bus.out, 128'd0);
        chk("out_valid", 128'(bus.out_valid), 128'd0);
        chk("ovf", 128'(bus.ovf), 128'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        beat(32'h0000FF10, 32'h0000FF10);
        beat(32'h0000FF10, 32'h0000FF10);
        idle();
        chk("lane0", 128'(bus.out[31:0]), 128'd256);
        chk("lane1", 128'(bus.out[63:32]), 128'd65025);

        step = "random";
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) < 6)
                setcfg({$urandom, $urandom, $urandom, $urandom, 5'($urandom)});
            else
                cycle(1'b0, $urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
                      $urandom, $urandom, '0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mac_cluster_pipe.md
Name: mac_cluster_pipe

Overview:
- Parametrised successor to the 4-lane configurable MAC cluster.
- NUM_LANES lanes of MIN_WIDTH operands, grouped per 4-lane quad into single, dual or quad precision.
- Adds a 2-stage valid-qualified pipeline, a global stall, configuration latched on cset, optional saturation and sticky overflow flags.
- Sits between the operand fabric and the accumulator readout.

Parameters:
- NUM_LANES, 4, lane count; multiple of 4.
- MIN_WIDTH, 8, per-lane operand width.
- ACC_WIDTH, 4*MIN_WIDTH, per-lane accumulator width.
- CONF_WIDTH, 5, mode field width in cfg.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- cset  in  1  config/preload strobe.
- en  in  1  pipeline advance enable; low = full stall.
- in_valid  in  1  operand beat valid.
- a  in  NUM_LANES*MIN_WIDTH  operand A; lane i = a[i*MIN_WIDTH +: MIN_WIDTH].
- b  in  NUM_LANES*MIN_WIDTH  operand B, same packing.
- cfg  in  NUM_LANES*ACC_WIDTH+CONF_WIDTH  cfg[CONF_WIDTH-1:0] = mode; lane i init value = cfg[CONF_WIDTH+i*ACC_WIDTH +: ACC_WIDTH].
- out  out  NUM_LANES*ACC_WIDTH  accumulators, same lane packing.
- out_valid  out  1  out updated by a beat this cycle.
- ovf  out  NUM_LANES  sticky per-lane overflow.

Behaviour:
- Mode bits:
  - [1:0] group size: 0 = single, 1 = dual, 2 = quad, 3 = single.
  - [2] accumulate.
  - [3] signed.
  - [4] saturate.
- Mode is latched into an internal register on cset only; cfg is ignored otherwise.
- Grouping:
  - Group size G = 1, 2 or 4 lanes, aligned within each quad.
  - Group operand = concatenation of its lanes' MIN_WIDTH slices, lowest lane least significant.
  - Group accumulator = concatenation of G lanes' ACC_WIDTH slices.
- Stage 1 (en=1): register p = A*B, full 2*G*MIN_WIDTH width, signed or unsigned per [3]; register v1 = in_valid.
- Stage 2 (en=1, v1=1):
  - Accumulate mode: acc = acc + ext(p). ext is sign- or zero-extension to G*ACC_WIDTH.
  - Non-accumulate mode: acc = ext(p).
  - out_valid = v1 registered. With en=1 and v1=0, acc holds and out_valid = 0.
- Latency: out reflects the beat 2 cycles after in_valid is sampled with en=1. Back-to-back beats give 1 result per cycle; there is no accumulate hazard.
- Overflow (accumulate mode only):
  - Unsigned: carry-out of the group sum.
  - Signed: operand signs equal and result sign differs.
  - On overflow, set ovf on every lane of the group (sticky).
  - If [4]=1, the group saturates: unsigned to all-ones; signed to max or min according to the operand sign.
  - If [4]=0, the group wraps.
- en=0: all registers hold (including out and ovf); out_valid = 0.
- cset (priority over en and in_valid):
  - acc ← cfg init values; mode register ← cfg mode.
  - v1 cleared (in-flight beat dropped); out_valid = 0; ovf cleared.
- Reset (asynchronous, any time including mid-stream): out = 0, out_valid = 0, ovf = 0, v1 = 0, p = 0, mode register = 0 (single, unsigned, no accumulate, no saturate).
- Changing mode without cset is impossible by construction. A stall between stage 1 and stage 2 preserves p exactly.

Test Plan:
- Single unsigned accumulate. Setup: cset with mode 0x04, inits 0. Stimulus: 3 consecutive beats with lane0 a=0xFF, b=0xFF. Response: out_valid high 2 cycles after the first beat; out0 = 65025, then 130050, then 195075.
- Single signed, no accumulate. Setup: mode 0x08. Stimulus: lane0 a=0xFF, b=0x02. Response: out0 = 0xFFFFFFFE; other lanes show their own products.
- Dual unsigned, no accumulate. Setup: mode 0x01. Stimulus: {a1,a0} = 0x0100, {b1,b0} = 0x0100. Response: out0 = 0x00010000, out1 = 0.
- Signed overflow, accumulate. Setup: init lane0 = 0x7FFFFFF0. Stimulus: a=0x7F, b=0x7F.
  - With mode 0x1C: out0 = 0x7FFFFFFF, ovf[0] = 1.
  - With mode 0x0C: out0 = 0x80003EF1, ovf[0] = 1.
  - A following cset clears ovf.
- Stall and flush.
  - Stimulus: beat, then en=0 for 3 cycles. Response: out and out_valid=0 frozen; the result appears 1 cycle after en returns.
  - Stimulus: cset in the cycle after a beat. Response: that beat is dropped and out equals the init values.
- Reset mid-stream. Stimulus: assert rst asynchronously between clock edges during accumulation. Response: out = 0, out_valid = 0 and ovf = 0 immediately; after release, mode behaves as single unsigned non-accumulate.
